// File: rtl/counter_pkg.sv
// counter_pkg: shared types and helpers for the modulo-N counter family.
//   state_t : RUN (counting allowed) / HALT (one-shot terminal reached)
//   start() : value a clear puts the counter at for a given direction
package counter_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    // Counting up starts at 0, counting down starts at N-1.
    function automatic int start(input logic up, input int n);
        return up ? 0 : n - 1;
    endfunction

endpackage

// File: rtl/counter_mod_next.sv
// counter_mod_next: purely combinational step calculator for one modulo-N stage.
//   q       : current count (0..N-1)
//   up      : 1 = increment, 0 = decrement
//   en, cin : enable and cascade carry-in; a step needs both
//   run     : stage is in RUN (not halted)
//   oneshot : 1 = hold at terminal instead of wrapping
//   nxt     : value q takes if this cycle steps
//   term    : q sits at the terminal value for the current direction
//   step    : this edge advances the counter
//   c       : carry/borrow-out, high only on the edge that wraps or halts
module counter_mod_next #(
    parameter int N = 12,
    parameter int W = $clog2(N)
) (
    input  logic [W-1:0] q,
    input  logic         up,
    input  logic         en,
    input  logic         cin,
    input  logic         run,
    input  logic         oneshot,
    output logic [W-1:0] nxt,
    output logic         term,
    output logic         step,
    output logic         c
);

    localparam logic [W-1:0] QMAX = W'(N - 1);

    // Terminal detection by compare, so it never depends on adder carry.
    assign term = up ? (q == QMAX) : (q == '0);
    assign step = en & cin & run;
    assign c    = step & term;

    // Away from the terminal, q+1 <= N-1 and q-1 >= 0, so W bits never overflow.
    always_comb begin
        nxt = q;
        if (!term)
            nxt = up ? q + W'(1) : q - W'(1);
        else if (!oneshot)
            nxt = up ? '0 : QMAX;
    end

endmodule

// File: rtl/counter_mod_ctrl.sv
// counter_mod_ctrl: modulo-N up/down counter, loadable, cascadable, with
// one-shot (stop-at-terminal) mode and out-of-range load detection.
//   clk, rstn : clock (rising edge), asynchronous active-low reset
//   en, cin   : count enable and cascade carry-in
//   up        : direction, 1 = increment
//   oneshot   : 1 = halt at terminal count instead of wrapping
//   clr       : synchronous clear to start value (highest priority)
//   load, d   : synchronous load; d >= N loads N-1 and flags err
//   q         : registered count
//   c         : combinational carry/borrow-out for chaining
//   done      : registered, high while halted in one-shot mode
//   err       : registered one-cycle pulse after an out-of-range load
module counter_mod_ctrl
    import counter_pkg::*;
#(
    parameter int N = 12,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         cin,
    input  logic         up,
    input  logic         oneshot,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         c,
    output logic         done,
    output logic         err
);

    localparam logic [W-1:0] QMAX = W'(N - 1);
    // One extra bit so N itself is representable for the range check.
    localparam logic [W:0]   NLIM = (W + 1)'(N);

    state_t       state, state_d;
    logic [W-1:0] q_d, nxt;
    logic         err_d, term, step;

    counter_mod_next #(.N(N), .W(W)) u_next (
        .q       (q),
        .up      (up),
        .en      (en),
        .cin     (cin),
        .run     (state == RUN),
        .oneshot (oneshot),
        .nxt     (nxt),
        .term    (term),
        .step    (step),
        .c       (c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RUN;
            q     <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            q     <= q_d;
            err   <= err_d;
        end
    end

    // Next-state: clr > load > step > hold. err defaults low so it pulses.
    always_comb begin
        state_d = state;
        q_d     = q;
        err_d   = 1'b0;
        if (clr) begin
            q_d     = W'(start(up, N));
            state_d = RUN;
        end else if (load) begin
            state_d = RUN;
            if ({1'b0, d} < NLIM) begin
                q_d = d;
            end else begin
                q_d   = QMAX;
                err_d = 1'b1;
            end
        end else if (step) begin
            q_d = nxt;
            if (term && oneshot)
                state_d = HALT;
        end
    end

    // Outputs derived from state; done is registered because state is.
    always_comb begin
        done = (state == HALT);
    end

endmodule

// File: tb/tb_counter_mod_ctrl.sv
module tb_counter_mod_ctrl;

    localparam int NL = 12;
    localparam int NH = 10;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0, cin = 1'b0, up = 1'b1, oneshot = 1'b0;
    logic       clr = 1'b0, load = 1'b0;
    logic [3:0] d = 4'd0;
    logic [3:0] q, hq;
    logic       c, hc, done, hdone, err, herr;

    always #5 clk = ~clk;

    counter_mod_ctrl #(.N(NL)) u_lo (
        .clk(clk), .rstn(rstn), .en(en), .cin(cin), .up(up), .oneshot(oneshot),
        .clr(clr), .load(load), .d(d), .q(q), .c(c), .done(done), .err(err)
    );

    counter_mod_ctrl #(.N(NH)) u_hi (
        .clk(clk), .rstn(rstn), .en(en), .cin(c), .up(up), .oneshot(1'b0),
        .clr(clr), .load(1'b0), .d(4'd0), .q(hq), .c(hc), .done(hdone), .err(herr)
    );

    typedef struct {
        logic [3:0] q;
        logic       done;
        logic       err;
        logic [3:0] hq;
        logic       hdone;
        logic       herr;
    } exp_t;

    exp_t sb[$];

    int ntests = 0;
    int nfail  = 0;

    // reference model state
    logic [3:0] m_q = 4'd0, m_hq = 4'd0;
    logic       m_halt = 1'b0, m_hhalt = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void ref_next(
        input  int         n,
        input  logic [3:0] cq,
        input  logic       ch,
        input  logic       e_, ci_, u_, o_, cl_, l_,
        input  logic [3:0] dv,
        output logic [3:0] nq,
        output logic       nh,
        output logic       ne,
        output logic       co
    );
        int   qi;
        logic t;
        qi = int'(cq);
        t  = u_ ? (qi == n - 1) : (qi == 0);
        co = e_ & ci_ & ~ch & t;
        nq = cq;
        nh = ch;
        ne = 1'b0;
        if (cl_) begin
            nq = 4'(u_ ? 0 : n - 1);
            nh = 1'b0;
        end else if (l_) begin
            nh = 1'b0;
            if (int'(dv) < n) nq = dv;
            else begin
                nq = 4'(n - 1);
                ne = 1'b1;
            end
        end else if (e_ & ci_ & ~ch) begin
            if (!t)       nq = 4'(u_ ? qi + 1 : qi - 1);
            else if (o_)  nh = 1'b1;
            else          nq = 4'(u_ ? 0 : n - 1);
        end
    endfunction

    // One clock: drive at negedge, check c, push expectation, compare after posedge.
    task automatic cyc(input logic e_, ci_, u_, o_, cl_, l_, input logic [3:0] dv);
        logic [3:0] nq, hnq;
        logic       nh, ne, ec, hnh, hne, hec;
        exp_t       ex, got;
        @(negedge clk);
        en = e_; cin = ci_; up = u_; oneshot = o_; clr = cl_; load = l_; d = dv;
        #1;
        ref_next(NL, m_q, m_halt, e_, ci_, u_, o_, cl_, l_, dv, nq, nh, ne, ec);
        ref_next(NH, m_hq, m_hhalt, e_, ec, u_, 1'b0, cl_, 1'b0, 4'd0, hnq, hnh, hne, hec);
        chk("c", c, ec);
        chk("hc", hc, hec);
        chk("c_off_term", c && (q != (u_ ? 4'd11 : 4'd0)), 0);
        m_q = nq; m_halt = nh; m_hq = hnq; m_hhalt = hnh;
        ex = '{q: nq, done: nh, err: ne, hq: hnq, hdone: hnh, herr: hne};
        sb.push_back(ex);
        @(posedge clk);
        #1;
        chk("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk("q", q, got.q);
            chk("done", done, got.done);
            chk("err", err, got.err);
            chk("hq", hq, got.hq);
            chk("hdone", hdone, got.hdone);
            chk("herr", herr, got.herr);
        end
        en = 1'b0; clr = 1'b0; load = 1'b0;
    endtask

    // Async reset between edges; outputs must clear without a clock.
    task automatic async_reset(input string tag);
        #2;
        rstn = 1'b0;
        #1;
        chk({tag, "_q"}, q, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_hq"}, hq, 0);
        m_q = 4'd0; m_halt = 1'b0; m_hq = 4'd0; m_hhalt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #2;
        chk("rst_q", q, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_hq", hq, 0);
        #11 rstn = 1'b1;

        // free-run up
        repeat (13) cyc(1, 1, 1, 0, 0, 0, 4'd0);

        // free-run down from clear, then direction changes mid-count
        cyc(0, 1, 0, 0, 1, 0, 4'd0);
        repeat (13) cyc(1, 1, 0, 0, 0, 0, 4'd0);
        repeat (3)  cyc(1, 1, 1, 0, 0, 0, 4'd0);
        repeat (2)  cyc(1, 1, 0, 0, 0, 0, 4'd0);

        // one-shot up: reach 11, halt, stay 20 cycles, ignore oneshot drop, reload
        cyc(0, 1, 1, 0, 1, 0, 4'd0);
        repeat (32) cyc(1, 1, 1, 1, 0, 0, 4'd0);
        chk("os_done", done, 1);
        chk("os_q", q, 11);
        repeat (3) cyc(1, 1, 1, 0, 0, 0, 4'd0);
        cyc(0, 1, 1, 1, 0, 1, 4'd3);
        repeat (4) cyc(1, 1, 1, 1, 0, 0, 4'd0);

        // load range check and priorities
        cyc(0, 1, 1, 0, 0, 1, 4'd14);
        cyc(0, 1, 1, 0, 0, 0, 4'd0);
        cyc(0, 1, 1, 0, 0, 1, 4'd11);
        cyc(0, 1, 1, 0, 0, 1, 4'd12);
        cyc(0, 1, 1, 0, 1, 1, 4'd14);
        cyc(1, 1, 1, 0, 0, 1, 4'd5);
        cyc(1, 1, 0, 0, 0, 1, 4'd15);

        // cascade 12 x 10: 120 steps returns both to 0
        cyc(0, 1, 1, 0, 1, 0, 4'd0);
        repeat (120) cyc(1, 1, 1, 0, 0, 0, 4'd0);
        chk("casc_lo", q, 0);
        chk("casc_hi", hq, 0);

        // async reset mid-count at q=7
        cyc(0, 1, 1, 0, 1, 0, 4'd0);
        repeat (7) cyc(1, 1, 1, 0, 0, 0, 4'd0);
        chk("pre_rst_q", q, 7);
        async_reset("rst_mid");
        repeat (3) cyc(1, 1, 1, 0, 0, 0, 4'd0);

        // async reset out of HALT
        cyc(0, 1, 1, 0, 1, 0, 4'd0);
        repeat (13) cyc(1, 1, 1, 1, 0, 0, 4'd0);
        async_reset("rst_halt");
        repeat (2) cyc(1, 1, 1, 1, 0, 0, 4'd0);

        // hold with en=0 or cin=0
        repeat (5) cyc(0, 1, 1, 0, 0, 0, 4'd0);
        repeat (5) cyc(1, 0, 1, 0, 0, 0, 4'd0);
        repeat (5) cyc(0, 0, 0, 0, 0, 0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
